// File: rtl/line_filter_pipe.sv
// line_filter_pipe: streaming RGB-to-luma converter with a per-line horizontal filter.
//
// Each accepted pixel is converted to luma Y and shifted into a five-tap window. The window
// replicates pixel 0 on the left and pixel N-1 on the right. Exactly one filtered pixel
// leaves per input pixel, with start/end-of-line markers.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   clk_en_i                qualifies every state update
//   enable_i                low: clears all state exactly like rst_i
//   mode_i[2:0]             filter select, latched on each accepted SOL pixel
//   in_valid_i/in_ready_o   input handshake (accept = valid & ready & clk_en)
//   in_sol_i, in_eol_i      input line markers
//   r_i, g_i, b_i           input pixel
//   out_valid_o             one-cycle pulse per output pixel (clk_en-high cycles only)
//   out_sol_o, out_eol_o    output line markers, aligned with out_valid_o
//   r_o, g_o, b_o           output pixel
//   line_err_o              sticky: SOL in mid-line, or line overrun
module line_filter_pipe #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LINE_LEN = 640,
    parameter int unsigned CNT_W    = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_en_i,
    input  logic              enable_i,
    input  logic [2:0]        mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sol_i,
    input  logic              in_eol_i,
    input  logic [DATA_W-1:0] r_i,
    input  logic [DATA_W-1:0] g_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              out_valid_o,
    output logic              out_sol_o,
    output logic              out_eol_o,
    output logic [DATA_W-1:0] r_o,
    output logic [DATA_W-1:0] g_o,
    output logic [DATA_W-1:0] b_o,
    output logic              line_err_o
);

    localparam int unsigned LumaW = DATA_W + 13;
    localparam int unsigned S4W   = DATA_W + 1;
    localparam int unsigned S5W   = DATA_W + 2;
    localparam int unsigned S6W   = DATA_W + 4;
    localparam int unsigned PixW  = 3 * DATA_W;

    typedef enum logic [1:0] {StIdle, StActive, StFlush1, StFlush2} state_e;

    state_e            state_q;
    logic              ready_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        mode_q;
    logic              err_q;
    logic              out_valid_q, out_sol_q, out_eol_q;
    logic [DATA_W-1:0] r_q, g_q, b_q;

    // ysh[0] is the newest Y; after the event for pixel j+2, ysh[4..0] = Y(j-2..j+2).
    logic [DATA_W-1:0] ysh_q [5];
    logic [DATA_W-1:0] ysh_d [5];
    // RGB delay line; entry 2 is the centre pixel for the pass-through/invert modes.
    logic [PixW-1:0]   psh_q [3];
    logic [PixW-1:0]   psh_d [3];

    logic [LumaW-1:0]  luma_sum;
    logic [DATA_W-1:0] y_in;
    logic [PixW-1:0]   pix_in;
    logic              accept, sol_acc, px_acc, flush, emit, forced, eol_eff;

    logic [DATA_W-1:0] ym2, ym1, yc, yp1, yp2;
    logic [S4W-1:0]    s4;
    logic [S5W-1:0]    s5;
    logic [S6W-1:0]    s6;
    logic [S4W-1:0]    d7;
    logic [DATA_W-1:0] f_r, f_g, f_b;

    // ---------------------------------------------------------------- input side
    always_comb begin
        luma_sum = LumaW'(1052) * LumaW'(r_i) + LumaW'(2064) * LumaW'(g_i)
                 + LumaW'(401) * LumaW'(b_i);
        y_in     = DATA_W'(luma_sum >> 12);
        pix_in   = {r_i, g_i, b_i};

        accept  = in_valid_i & ready_q & clk_en_i;
        sol_acc = accept & in_sol_i;
        px_acc  = accept & ~in_sol_i & (state_q == StActive);
        flush   = clk_en_i & ((state_q == StFlush1) | (state_q == StFlush2));

        // The last pixel the counter allows ends the line even without in_eol_i.
        forced  = sol_acc ? (LINE_LEN == 1) : (cnt_q == CNT_W'(LINE_LEN - 1));
        eol_eff = in_eol_i | forced;

        // Event index equals cnt_q; output j = event - 2. FLUSH2 always carries j = N-1.
        emit = ((px_acc | (flush & (state_q == StFlush1))) & (cnt_q >= CNT_W'(2)))
             | (flush & (state_q == StFlush2));
    end

    // ---------------------------------------------------------------- window update
    always_comb begin
        ysh_d = ysh_q;
        psh_d = psh_q;
        if (sol_acc) begin
            // Seeding the whole window with pixel 0 gives left-edge replication.
            for (int i = 0; i < 5; i++) ysh_d[i] = y_in;
            for (int i = 0; i < 3; i++) psh_d[i] = pix_in;
        end else if (px_acc || flush) begin
            for (int i = 4; i > 0; i--) ysh_d[i] = ysh_q[i-1];
            for (int i = 2; i > 0; i--) psh_d[i] = psh_q[i-1];
            // Flush cycles re-insert the newest entry: right-edge replication.
            ysh_d[0] = px_acc ? y_in : ysh_q[0];
            psh_d[0] = px_acc ? pix_in : psh_q[0];
        end
    end

    // ---------------------------------------------------------------- filter
    always_comb begin
        ym2 = ysh_d[4];
        ym1 = ysh_d[3];
        yc  = ysh_d[2];
        yp1 = ysh_d[1];
        yp2 = ysh_d[0];

        s4 = S4W'(yc) + S4W'(yp1);
        s5 = S5W'(ym1) + (S5W'(yc) << 1) + S5W'(yp1);
        s6 = S6W'(ym2) + (S6W'(ym1) << 2) + (S6W'(yc) << 2) + (S6W'(yc) << 1)
           + (S6W'(yp1) << 2) + S6W'(yp2);
        d7 = (yp1 >= ym1) ? (S4W'(yp1) - S4W'(ym1)) : (S4W'(ym1) - S4W'(yp1));

        {f_r, f_g, f_b} = psh_d[2];
        case (mode_q)
            3'd0: {f_r, f_g, f_b} = psh_d[2];
            3'd1: {f_r, f_g, f_b} = ~psh_d[2];
            3'd2: {f_r, f_g, f_b} = {3{yc}};
            3'd3: {f_r, f_g, f_b} = {3{~yc}};
            3'd4: {f_r, f_g, f_b} = {3{DATA_W'(s4 >> 1)}};
            3'd5: {f_r, f_g, f_b} = {3{DATA_W'(s5 >> 2)}};
            3'd6: {f_r, f_g, f_b} = {3{DATA_W'(s6 >> 4)}};
            3'd7: {f_r, f_g, f_b} = {3{d7[DATA_W] ? {DATA_W{1'b1}} : d7[DATA_W-1:0]}};
            default: {f_r, f_g, f_b} = psh_d[2];
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            for (int i = 0; i < 5; i++) ysh_q[i] <= '0;
            for (int i = 0; i < 3; i++) psh_q[i] <= '0;
        end else if (clk_en_i) begin
            ysh_q       <= ysh_d;
            psh_q       <= psh_d;
            out_valid_q <= emit;
            if (emit) begin
                r_q       <= f_r;
                g_q       <= f_g;
                b_q       <= f_b;
                out_sol_q <= (cnt_q == CNT_W'(2));
                out_eol_q <= (state_q == StFlush2);
            end

            ready_q <= 1'b1;
            if (sol_acc) begin
                // A SOL mid-line abandons the old line's pending outputs.
                if (state_q == StActive) err_q <= 1'b1;
                mode_q <= mode_i;
                cnt_q  <= CNT_W'(1);
                if (eol_eff) begin
                    state_q <= StFlush1;
                    ready_q <= 1'b0;
                    if (!in_eol_i) err_q <= 1'b1;
                end else begin
                    state_q <= StActive;
                end
            end else begin
                unique case (state_q)
                    StIdle: ;  // non-SOL pixels are accepted and dropped
                    StActive: begin
                        if (px_acc) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (eol_eff) begin
                                state_q <= StFlush1;
                                ready_q <= 1'b0;
                                if (!in_eol_i) err_q <= 1'b1;
                            end
                        end
                    end
                    StFlush1: begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= StFlush2;
                        ready_q <= 1'b0;
                    end
                    StFlush2: begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Registered results are presented only on clk_en-high cycles, so each is one pulse.
    always_comb begin
        in_ready_o  = ready_q;
        out_valid_o = out_valid_q & clk_en_i;
        out_sol_o   = out_sol_q & out_valid_o;
        out_eol_o   = out_eol_q & out_valid_o;
        r_o         = r_q;
        g_o         = g_q;
        b_o         = b_q;
        line_err_o  = err_q;
    end

endmodule
